mem_controller: RTL and testbench

Responder side of the LSU memory handshake. Accepts read and write requests from `NUM_CONSUMERS` load/store units and arbitrates them round-robin onto one external data-memory port. It returns read data or a write acknowledgement to the granted LSU and holds the result until that LSU releases its request. It sits between the per-thread LSUs of a core and the shared data memory.

---
 rtl/mem_pkg.sv | 19 +
 rtl/mem_controller_rr_arbiter.sv | 32 +++
 rtl/mem_controller.sv | 201 ++++++++++++++++++++
 tb/tb_mem_controller.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared constants for the LSU-facing memory controller and its arbiter.
package mem_pkg;

  // Controller FSM encoding, kept as plain constants for legacy tooling.
  localparam logic [2:0] ST_IDLE       = 3'd0;
  localparam logic [2:0] ST_READ_WAIT  = 3'd1;
  localparam logic [2:0] ST_WRITE_WAIT = 3'd2;
  localparam logic [2:0] ST_RELAY      = 3'd3;
  localparam logic [2:0] ST_DRAIN      = 3'd4;

  localparam int MEM_ADDR_BITS = 8;
  localparam int MEM_DATA_BITS = 8;

  // Index width for a port count; a single port still needs one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mem_controller_rr_arbiter.sv
// Round-robin priority search: the first requester at or after rr_ptr wins.
module rr_arbiter
  import mem_pkg::*;
#(
  parameter int NUM_CONSUMERS = 4,
  parameter int IDX_W         = idx_width(NUM_CONSUMERS)
) (
  input  logic [NUM_CONSUMERS-1:0] req,
  input  logic [IDX_W-1:0]         rr_ptr,
  output logic                     grant_valid,
  output logic [IDX_W-1:0]         grant_idx
);

  // Scan from the farthest offset down so the closest requester is written last.
  always_comb begin
    logic [IDX_W:0] cand;
    grant_valid = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = NUM_CONSUMERS - 1; k >= 0; k--) begin
      cand = {1'b0, rr_ptr} + (IDX_W + 1)'(k);
      if (cand >= (IDX_W + 1)'(NUM_CONSUMERS)) begin
        cand = cand - (IDX_W + 1)'(NUM_CONSUMERS);
      end
      if (req[cand[IDX_W-1:0]]) begin
        grant_valid = 1'b1;
        grant_idx   = cand[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/mem_controller.sv
// Memory controller: round-robin arbitration of LSU read/write requests onto
// one data-memory port, with one outstanding memory transaction at a time.
module mem_controller
  import mem_pkg::*;
#(
  parameter int NUM_CONSUMERS = 4,
  parameter int ADDR_BITS     = MEM_ADDR_BITS,
  parameter int DATA_BITS     = MEM_DATA_BITS
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [NUM_CONSUMERS-1:0]           consumer_read_valid,
  input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_read_address,
  output logic [NUM_CONSUMERS-1:0]           consumer_read_ready,
  output logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_read_data,
  input  logic [NUM_CONSUMERS-1:0]           consumer_write_valid,
  input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_write_address,
  input  logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_write_data,
  output logic [NUM_CONSUMERS-1:0]           consumer_write_ready,
  output logic                               mem_read_valid,
  output logic [ADDR_BITS-1:0]               mem_read_address,
  input  logic                               mem_read_ready,
  input  logic [DATA_BITS-1:0]               mem_read_data,
  output logic                               mem_write_valid,
  output logic [ADDR_BITS-1:0]               mem_write_address,
  output logic [DATA_BITS-1:0]               mem_write_data,
  input  logic                               mem_write_ready
);

  localparam int IDX_W = idx_width(NUM_CONSUMERS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CONSUMERS - 1);

  logic [2:0]               state_q, state_d;
  logic [IDX_W-1:0]         grant_q, grant_d;
  logic [IDX_W-1:0]         rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]         rr_next;
  logic [NUM_CONSUMERS-1:0] served_q, served_d;
  logic                     dropped_q, dropped_d;
  logic [NUM_CONSUMERS-1:0] rready_q, rready_d;
  logic [NUM_CONSUMERS-1:0] wready_q, wready_d;
  logic [DATA_BITS-1:0]     rdata_q [NUM_CONSUMERS];
  logic [DATA_BITS-1:0]     rdata_d [NUM_CONSUMERS];
  logic                     mrv_q, mrv_d;
  logic [ADDR_BITS-1:0]     mra_q, mra_d;
  logic                     mwv_q, mwv_d;
  logic [ADDR_BITS-1:0]     mwa_q, mwa_d;
  logic [DATA_BITS-1:0]     mwd_q, mwd_d;

  logic [NUM_CONSUMERS-1:0] any_valid;
  logic [NUM_CONSUMERS-1:0] pending;
  logic                     arb_valid;
  logic [IDX_W-1:0]         arb_idx;

  logic [ADDR_BITS-1:0]     rd_addr [NUM_CONSUMERS];
  logic [ADDR_BITS-1:0]     wr_addr [NUM_CONSUMERS];
  logic [DATA_BITS-1:0]     wr_data [NUM_CONSUMERS];

  // Unflatten the per-consumer buses and flatten the held read data back out.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_CONSUMERS; gi++) begin : g_slice
      assign rd_addr[gi] = consumer_read_address[gi*ADDR_BITS +: ADDR_BITS];
      assign wr_addr[gi] = consumer_write_address[gi*ADDR_BITS +: ADDR_BITS];
      assign wr_data[gi] = consumer_write_data[gi*DATA_BITS +: DATA_BITS];
      assign consumer_read_data[gi*DATA_BITS +: DATA_BITS] = rdata_q[gi];
    end
  endgenerate

  // A consumer already answered stays out of arbitration until it lets go of both valids.
  assign any_valid = consumer_read_valid | consumer_write_valid;
  assign pending   = any_valid & ~served_q;
  assign rr_next   = (grant_q == LAST_IDX) ? '0 : grant_q + 1'b1;

  rr_arbiter #(
    .NUM_CONSUMERS(NUM_CONSUMERS),
    .IDX_W        (IDX_W)
  ) u_arb (
    .req        (pending),
    .rr_ptr     (rr_ptr_q),
    .grant_valid(arb_valid),
    .grant_idx  (arb_idx)
  );

  // Next-state logic: grant, wait on memory, relay the answer or drain it.
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    rr_ptr_d  = rr_ptr_q;
    dropped_d = dropped_q;
    served_d  = served_q & any_valid;
    rready_d  = rready_q;
    wready_d  = wready_q;
    rdata_d   = rdata_q;
    mrv_d     = mrv_q;
    mra_d     = mra_q;
    mwv_d     = mwv_q;
    mwa_d     = mwa_q;
    mwd_d     = mwd_q;
    case (state_q)
      ST_IDLE: begin
        if (arb_valid) begin
          grant_d   = arb_idx;
          dropped_d = 1'b0;
          if (consumer_read_valid[arb_idx]) begin
            mrv_d   = 1'b1;
            mra_d   = rd_addr[arb_idx];
            state_d = ST_READ_WAIT;
          end else begin
            mwv_d   = 1'b1;
            mwa_d   = wr_addr[arb_idx];
            mwd_d   = wr_data[arb_idx];
            state_d = ST_WRITE_WAIT;
          end
        end
      end
      ST_READ_WAIT: begin
        if (!consumer_read_valid[grant_q]) dropped_d = 1'b1;
        if (mem_read_ready && mrv_q) begin
          mrv_d = 1'b0;
          if (dropped_q || !consumer_read_valid[grant_q]) begin
            state_d = ST_DRAIN;
          end else begin
            rready_d[grant_q] = 1'b1;
            rdata_d[grant_q]  = mem_read_data;
            served_d[grant_q] = 1'b1;
            state_d           = ST_RELAY;
          end
        end
      end
      ST_WRITE_WAIT: begin
        if (!consumer_write_valid[grant_q]) dropped_d = 1'b1;
        if (mem_write_ready && mwv_q) begin
          mwv_d = 1'b0;
          if (dropped_q || !consumer_write_valid[grant_q]) begin
            state_d = ST_DRAIN;
          end else begin
            wready_d[grant_q] = 1'b1;
            served_d[grant_q] = 1'b1;
            state_d           = ST_RELAY;
          end
        end
      end
      ST_RELAY: begin
        if (rready_q[grant_q] ? !consumer_read_valid[grant_q]
                              : !consumer_write_valid[grant_q]) begin
          rready_d = '0;
          wready_d = '0;
          rr_ptr_d = rr_next;
          state_d  = ST_IDLE;
        end
      end
      ST_DRAIN: begin
        rr_ptr_d = rr_next;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers; reset aborts any transaction in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      grant_q   <= '0;
      rr_ptr_q  <= '0;
      served_q  <= '0;
      dropped_q <= 1'b0;
      rready_q  <= '0;
      wready_q  <= '0;
      for (int i = 0; i < NUM_CONSUMERS; i++) rdata_q[i] <= '0;
      mrv_q     <= 1'b0;
      mra_q     <= '0;
      mwv_q     <= 1'b0;
      mwa_q     <= '0;
      mwd_q     <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      rr_ptr_q  <= rr_ptr_d;
      served_q  <= served_d;
      dropped_q <= dropped_d;
      rready_q  <= rready_d;
      wready_q  <= wready_d;
      rdata_q   <= rdata_d;
      mrv_q     <= mrv_d;
      mra_q     <= mra_d;
      mwv_q     <= mwv_d;
      mwa_q     <= mwa_d;
      mwd_q     <= mwd_d;
    end
  end

  assign consumer_read_ready  = rready_q;
  assign consumer_write_ready = wready_q;
  assign mem_read_valid       = mrv_q;
  assign mem_read_address     = mra_q;
  assign mem_write_valid      = mwv_q;
  assign mem_write_address    = mwa_q;
  assign mem_write_data       = mwd_q;

endmodule

// File: tb/tb_mem_controller.sv
// Bench for mem_controller: transaction-level reference model checked every
// cycle, a latency-programmable memory responder, and directed scenarios.
module tb_mem_controller;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  rv = '0, wv = '0;
  logic [31:0] raddr = '0, waddr = '0, wdata = '0;
  logic [3:0]  rready, wready;
  logic [31:0] rdata;
  logic        mrv, mwv;
  logic [7:0]  mra, mwa, mwd;
  logic        mr_ready = 1'b0, mw_ready = 1'b0;
  logic [7:0]  mr_data = '0;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  mem_controller #(.NUM_CONSUMERS(4), .ADDR_BITS(8), .DATA_BITS(8)) dut (
    .clk(clk), .reset(reset),
    .consumer_read_valid(rv), .consumer_read_address(raddr),
    .consumer_read_ready(rready), .consumer_read_data(rdata),
    .consumer_write_valid(wv), .consumer_write_address(waddr),
    .consumer_write_data(wdata), .consumer_write_ready(wready),
    .mem_read_valid(mrv), .mem_read_address(mra),
    .mem_read_ready(mr_ready), .mem_read_data(mr_data),
    .mem_write_valid(mwv), .mem_write_address(mwa),
    .mem_write_data(mwd), .mem_write_ready(mw_ready)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- memory responder ----------------
  typedef struct { bit wr; logic [7:0] addr; logic [7:0] data; } mtx_t;
  mtx_t       mlog[$];
  logic [7:0] mem [256];
  int rd_lat = 0, wr_lat = 0, rd_cnt = 0, wr_cnt = 0;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h5A;
    forever begin
      @(negedge clk);
      if (mrv && !mr_ready) begin
        if (rd_cnt >= rd_lat) begin
          mr_ready = 1'b1;
          mr_data  = mem[mra];
          mlog.push_back('{1'b0, mra, mem[mra]});
          $display("mem read  addr=%02h data=%02h t=%0t", mra, mem[mra], $time);
          rd_cnt = 0;
        end else rd_cnt++;
      end else begin
        mr_ready = 1'b0;
        if (!mrv) rd_cnt = 0;
      end
      if (mwv && !mw_ready) begin
        if (wr_cnt >= wr_lat) begin
          mw_ready = 1'b1;
          mem[mwa] = mwd;
          mlog.push_back('{1'b1, mwa, mwd});
          $display("mem write addr=%02h data=%02h t=%0t", mwa, mwd, $time);
          wr_cnt = 0;
        end else wr_cnt++;
      end else begin
        mw_ready = 1'b0;
        if (!mwv) wr_cnt = 0;
      end
    end
  end

  // ---------------- reference model ----------------
  // One transaction record: who was picked, whether memory is still busy,
  // whether the requester walked away, and whether the answer is being held.
  bit         t_busy, t_rd, t_at_mem, t_lost, t_flush;
  logic [1:0] t_who, m_ptr;
  bit [3:0]   m_served;
  logic [3:0] e_rready, e_wready;
  logic [31:0] e_rdata;
  logic       e_mrv, e_mwv;
  logic [7:0] e_mra, e_mwa, e_mwd;

  task automatic model_step();
    bit [3:0]   prev_served;
    bit         found;
    logic [1:0] cand, pick;
    bit         still;
    if (reset) begin
      t_busy = 0; t_rd = 0; t_at_mem = 0; t_lost = 0; t_flush = 0;
      t_who = '0; m_ptr = '0; m_served = '0;
      e_rready = '0; e_wready = '0; e_rdata = '0;
      e_mrv = 0; e_mwv = 0; e_mra = '0; e_mwa = '0; e_mwd = '0;
      return;
    end
    prev_served = m_served;
    m_served = m_served & (rv | wv);
    if (!t_busy) begin
      found = 0; pick = '0;
      for (int k = 0; k < 4; k++) begin
        cand = m_ptr + 2'(k);
        if (!found && (rv[cand] || wv[cand]) && !prev_served[cand]) begin
          found = 1; pick = cand;
        end
      end
      if (found) begin
        t_busy = 1; t_who = pick; t_rd = rv[pick]; t_at_mem = 1; t_lost = 0; t_flush = 0;
        if (t_rd) begin
          e_mrv = 1; e_mra = raddr[pick*8 +: 8];
        end else begin
          e_mwv = 1; e_mwa = waddr[pick*8 +: 8]; e_mwd = wdata[pick*8 +: 8];
        end
      end
    end else if (t_at_mem) begin
      still = t_rd ? rv[t_who] : wv[t_who];
      if (!still) t_lost = 1;
      if (t_rd ? mr_ready : mw_ready) begin
        t_at_mem = 0; e_mrv = 0; e_mwv = 0;
        if (t_lost) t_flush = 1;
        else begin
          m_served[t_who] = 1'b1;
          if (t_rd) begin
            e_rready[t_who] = 1'b1;
            e_rdata[t_who*8 +: 8] = mr_data;
          end else e_wready[t_who] = 1'b1;
        end
      end
    end else if (t_flush) begin
      t_busy = 0; t_flush = 0; m_ptr = t_who + 2'd1;
    end else begin
      still = t_rd ? rv[t_who] : wv[t_who];
      if (!still) begin
        e_rready = '0; e_wready = '0; t_busy = 0; m_ptr = t_who + 2'd1;
      end
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // Every-cycle comparison of all DUT outputs against the model.
  initial begin
    @(posedge clk);
    forever begin
      @(negedge clk);
      check("cyc_rready", 64'(rready), 64'(e_rready));
      check("cyc_wready", 64'(wready), 64'(e_wready));
      check("cyc_rdata",  64'(rdata),  64'(e_rdata));
      check("cyc_mrv",    64'(mrv),    64'(e_mrv));
      check("cyc_mra",    64'(mra),    64'(e_mra));
      check("cyc_mwv",    64'(mwv),    64'(e_mwv));
      check("cyc_mwa",    64'(mwa),    64'(e_mwa));
      check("cyc_mwd",    64'(mwd),    64'(e_mwd));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_ready(input logic [1:0] i, input bit rd, input int budget);
    int c = 0;
    while (((rd ? rready[i] : wready[i]) !== 1'b1) && c < budget) begin
      @(negedge clk); c++;
    end
    check($sformatf("wait_ready%0d_%s", i, rd ? "rd" : "wr"),
          64'(rd ? rready[i] : wready[i]), 64'd1);
  endtask

  // All raised read valids are dropped as soon as their ready is seen.
  task automatic serve_reads(input int budget);
    int c = 0;
    while (rv != 4'h0 && c < budget) begin
      @(negedge clk); c++;
      for (int i = 0; i < 4; i++) if (rready[i] === 1'b1) rv[i] = 1'b0;
    end
    check("serve_reads_done", 64'(rv), 64'd0);
  endtask

  task automatic check_order(input int base, input logic [31:0] exp_addrs, input string tag);
    check({tag, "_count"}, 64'(mlog.size() - base), 64'd4);
    for (int k = 0; k < 4; k++) begin
      if (base + k < mlog.size())
        check($sformatf("%s_slot%0d", tag, k), 64'(mlog[base+k].addr), 64'(exp_addrs[k*8 +: 8]));
    end
  endtask

  int  base;
  int  hits;
  bit  seen3;

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(1);
    check("rst_rready", 64'(rready), 64'd0);
    check("rst_mrv",    64'(mrv),    64'd0);

    // Single read: consumer 0, address 0x10, memory latency 3.
    mem[8'h10] = 8'hA5; rd_lat = 3;
    raddr[7:0] = 8'h10; rv[0] = 1'b1; base = mlog.size();
    tick(1);
    check("t1_mrv", 64'(mrv), 64'd1);
    check("t1_mra", 64'(mra), 64'h10);
    wait_ready(2'd0, 1'b1, 20);
    check("t1_data", 64'(rdata[7:0]), 64'hA5);
    tick(3);
    check("t1_hold", 64'(rready[0]), 64'd1);
    rv[0] = 1'b0;
    tick(1);
    check("t1_release", 64'(rready[0]), 64'd0);
    tick(2);

    // Single write: consumer 2 writes 0x3C to 0x20.
    wr_lat = 1; waddr[23:16] = 8'h20; wdata[23:16] = 8'h3C; wv[2] = 1'b1; base = mlog.size();
    wait_ready(2'd2, 1'b0, 20);
    check("t2_log_n", 64'(mlog.size() - base), 64'd1);
    if (mlog.size() > base) begin
      check("t2_log_wr",   64'(mlog[base].wr),   64'd1);
      check("t2_log_addr", 64'(mlog[base].addr), 64'h20);
      check("t2_log_data", 64'(mlog[base].data), 64'h3C);
    end
    wv[2] = 1'b0;
    tick(2);

    // Contention from rr_ptr=0, then from rr_ptr=2.
    reset = 1'b1; tick(1); reset = 1'b0;
    rd_lat = 0;
    raddr = {8'h43, 8'h42, 8'h41, 8'h40}; base = mlog.size(); rv = 4'hF;
    serve_reads(80);
    check_order(base, {8'h43, 8'h42, 8'h41, 8'h40}, "rr0");
    tick(2);
    rv[1] = 1'b1; wait_ready(2'd1, 1'b1, 20); rv[1] = 1'b0; tick(2);
    raddr = {8'h53, 8'h52, 8'h51, 8'h50}; base = mlog.size(); rv = 4'hF;
    serve_reads(80);
    check_order(base, {8'h51, 8'h50, 8'h53, 8'h52}, "rr2");
    tick(2);

    // No double service: consumer 1 keeps valid 10 cycles past ready.
    raddr[15:8] = 8'h60; rv[1] = 1'b1; base = mlog.size();
    wait_ready(2'd1, 1'b1, 20);
    tick(10);
    check("t4_held", 64'(rready[1]), 64'd1);
    rv[1] = 1'b0;
    tick(3);
    hits = 0;
    for (int k = base; k < mlog.size(); k++) if (mlog[k].addr == 8'h60) hits++;
    check("t4_one_txn", 64'(hits), 64'd1);

    // Drop during READ_WAIT: consumer 3 walks away, memory still completes.
    rd_lat = 5; raddr[31:24] = 8'h70; rv[3] = 1'b1; base = mlog.size();
    tick(1);
    check("t5_mrv", 64'(mrv), 64'd1);
    tick(1);
    rv[3] = 1'b0;
    seen3 = 1'b0;
    for (int c = 0; c < 12; c++) begin
      tick(1);
      if (rready[3] === 1'b1) seen3 = 1'b1;
    end
    check("t5_no_ready", 64'(seen3), 64'd0);
    check("t5_mem_done", 64'(mlog.size() - base), 64'd1);
    if (mlog.size() > base) check("t5_mem_addr", 64'(mlog[base].addr), 64'h70);
    check("t5_mrv_low", 64'(mrv), 64'd0);

    // Reset in WRITE_WAIT, then a fresh read.
    wr_lat = 6; waddr[7:0] = 8'h80; wdata[7:0] = 8'h11; wv[0] = 1'b1;
    tick(1);
    check("t6_mwv", 64'(mwv), 64'd1);
    tick(2);
    reset = 1'b1;
    tick(1);
    check("t6_rready", 64'(rready), 64'd0);
    check("t6_wready", 64'(wready), 64'd0);
    check("t6_rdata",  64'(rdata),  64'd0);
    check("t6_mrv",    64'(mrv),    64'd0);
    check("t6_mra",    64'(mra),    64'd0);
    check("t6_mwv",    64'(mwv),    64'd0);
    check("t6_mwa",    64'(mwa),    64'd0);
    check("t6_mwd",    64'(mwd),    64'd0);
    wv[0] = 1'b0; reset = 1'b0;
    tick(2);
    rd_lat = 1; raddr[23:16] = 8'h10; rv[2] = 1'b1;
    wait_ready(2'd2, 1'b1, 20);
    check("t6_fresh_data", 64'(rdata[23:16]), 64'hA5);
    rv[2] = 1'b0;
    tick(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
